// File: rtl/mem_model_pkg.sv
// mem_model_pkg: shared types and helpers for the multi-channel slow memory model.
//   mem_state_e : transaction FSM states (idle, counting latency, response cycle).
//   clog2_min1  : $clog2 that never returns less than 1, for index-width ports.
package mem_model_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StBusy,
    StResp
  } mem_state_e;

  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick among NUM_CH requesters.
//   req         : per-channel request vector
//   last_grant  : index of the previously granted channel (pointer lives in the parent)
//   grant_oh    : one-hot grant
//   grant_idx   : binary grant index
//   grant_valid : at least one request is present
// The search starts at last_grant+1 and wraps modulo NUM_CH.
module rr_arbiter
  import mem_model_pkg::*;
#(
  parameter int unsigned NUM_CH = 2
) (
  input  logic [NUM_CH-1:0]                 req,
  input  logic [clog2_min1(NUM_CH)-1:0]     last_grant,
  output logic [NUM_CH-1:0]                 grant_oh,
  output logic [clog2_min1(NUM_CH)-1:0]     grant_idx,
  output logic                              grant_valid
);

  localparam int unsigned ChW = clog2_min1(NUM_CH);

  always_comb begin
    int unsigned c;
    c           = 0;
    grant_oh    = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      c = int'(last_grant) + i;
      if (c >= NUM_CH) c = c - NUM_CH;
      if (!grant_valid && req[c]) begin
        grant_valid = 1'b1;
        grant_idx   = ChW'(c);
        grant_oh[c] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/multi_ch_slow_memory.sv
// multi_ch_slow_memory: line-organised backing store shared by NUM_CH channels.
// A round-robin arbiter serves one channel at a time; each served request completes
// LATENCY cycles after grant with a one-cycle mem_ready pulse on its channel.
//   clk, rst             : rising-edge clock, synchronous active-high reset
//   mem_read, mem_write  : per-channel level requests, held until ready
//   mem_addr, mem_wdata  : per-channel line address / write line (channel c at slice c)
//   mem_rdata, mem_ready : per-channel read line / completion pulse
//   busy                 : a transaction is in flight
//   grant_ch             : channel currently (or most recently) served
//   proto_err            : sticky, read and write seen together on one channel
module multi_ch_slow_memory
  import mem_model_pkg::*;
#(
  parameter int unsigned NUM_CH     = 2,
  parameter int unsigned ADDR_W     = 28,
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_CH-1:0]             mem_read,
  input  logic [NUM_CH-1:0]             mem_write,
  input  logic [NUM_CH*ADDR_W-1:0]      mem_addr,
  input  logic [NUM_CH*LINE_W-1:0]      mem_wdata,
  output logic [NUM_CH*LINE_W-1:0]      mem_rdata,
  output logic [NUM_CH-1:0]             mem_ready,
  output logic                          busy,
  output logic [clog2_min1(NUM_CH)-1:0] grant_ch,
  output logic                          proto_err
);

  localparam int unsigned ChW  = clog2_min1(NUM_CH);
  localparam int unsigned CntW = $clog2(LATENCY + 1);

  // Not reset, so a testbench may preload it.
  logic [LINE_W-1:0] mem [2**DEPTH_LOG2];

  mem_state_e state_q, state_d;

  logic [ChW-1:0]          ch_q, last_q;
  logic                    wr_q, perr_q;
  logic [DEPTH_LOG2-1:0]   idx_q;
  logic [LINE_W-1:0]       wdata_q, line_q;
  logic [CntW-1:0]         cnt_q;
  logic [NUM_CH*LINE_W-1:0] rdata_q;

  logic [NUM_CH-1:0]       req, gnt_oh;
  logic [ChW-1:0]          gnt_idx, resp_ch;
  logic                    gnt_valid, take, gnt_wr, enter_resp, resp_rd;
  logic [DEPTH_LOG2-1:0]   gnt_line;
  logic [LINE_W-1:0]       gnt_wdata, resp_line;

  // Upper line-address bits are deliberately ignored, so addresses wrap.
  logic unused_addr_bits;
  assign unused_addr_bits = ^mem_addr;

  assign req       = mem_read | mem_write;
  assign take      = (state_q == StIdle) && gnt_valid;
  assign gnt_wr    = |(gnt_oh & mem_write);  // write wins when both are asserted
  assign gnt_line  = mem_addr[int'(gnt_idx)*ADDR_W +: DEPTH_LOG2];
  assign gnt_wdata = mem_wdata[int'(gnt_idx)*LINE_W +: LINE_W];

  rr_arbiter #(
    .NUM_CH(NUM_CH)
  ) u_arb (
    .req        (req),
    .last_grant (last_q),
    .grant_oh   (gnt_oh),
    .grant_idx  (gnt_idx),
    .grant_valid(gnt_valid)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (gnt_valid) state_d = (LATENCY > 1) ? StBusy : StResp;
      StBusy:  if (cnt_q == CntW'(1)) state_d = StResp;
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // With LATENCY==1 RESP is entered straight from the grant edge, so the response
  // fields come from the live grant rather than the captured registers.
  assign enter_resp = (state_d == StResp) && (state_q != StResp);
  assign resp_ch    = take ? gnt_idx : ch_q;
  assign resp_rd    = take ? !gnt_wr : !wr_q;
  assign resp_line  = take ? mem[gnt_line] : line_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q    <= '0;
      last_q  <= ChW'(NUM_CH - 1);
      wr_q    <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      line_q  <= '0;
      cnt_q   <= '0;
      rdata_q <= '0;
      perr_q  <= 1'b0;
    end else begin
      if (|(mem_read & mem_write)) perr_q <= 1'b1;
      if (take) begin
        ch_q    <= gnt_idx;
        last_q  <= gnt_idx;
        wr_q    <= gnt_wr;
        idx_q   <= gnt_line;
        wdata_q <= gnt_wdata;
        line_q  <= mem[gnt_line];
        cnt_q   <= CntW'(LATENCY - 1);
      end else if (state_q == StBusy) begin
        cnt_q <= cnt_q - CntW'(1);
      end
      if (enter_resp && resp_rd) rdata_q[int'(resp_ch)*LINE_W +: LINE_W] <= resp_line;
    end
  end

  // Write commits on the edge that ends RESP; a reset on that edge aborts it.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == StResp) && wr_q) mem[idx_q] <= wdata_q;
  end

  // Outputs. Ready is masked by rst so an aborted transaction never signals completion.
  always_comb begin
    mem_ready = '0;
    if ((state_q == StResp) && !rst) mem_ready[ch_q] = 1'b1;
    busy      = (state_q != StIdle);
    grant_ch  = ch_q;
    mem_rdata = rdata_q;
    proto_err = perr_q;
  end

endmodule

// File: tb/tb_multi_ch_slow_memory.sv
// Scoreboard bench: stimulus pushes the expected response of each request into a
// queue; negedge monitors pop and compare whenever a mem_ready pulse appears.
module tb_multi_ch_slow_memory;

  localparam int unsigned NCH = 2, AW = 28, LW = 128, DL = 10, LAT = 4;
  localparam logic [LW-1:0] PAA = {16{8'hAA}};
  localparam logic [LW-1:0] P99 = {16{8'h99}};

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic [NCH-1:0]    mem_read = '0, mem_write = '0, mem_ready;
  logic [NCH*AW-1:0] mem_addr = '0;
  logic [NCH*LW-1:0] mem_wdata = '0, mem_rdata;
  logic              busy, proto_err;
  logic [0:0]        grant_ch;

  logic [3:0]  mem_read4 = '0, mem_write4 = '0, mem_ready4;
  logic [31:0] mem_addr4 = '0;
  logic [63:0] mem_wdata4 = '0, mem_rdata4;
  logic        busy4, proto_err4;
  logic [1:0]  grant_ch4;

  always #5 clk = ~clk;

  multi_ch_slow_memory #(
    .NUM_CH(NCH), .ADDR_W(AW), .LINE_W(LW), .DEPTH_LOG2(DL), .LATENCY(LAT)
  ) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready), .busy(busy),
    .grant_ch(grant_ch), .proto_err(proto_err)
  );

  multi_ch_slow_memory #(
    .NUM_CH(4), .ADDR_W(8), .LINE_W(16), .DEPTH_LOG2(4), .LATENCY(1)
  ) dut4 (
    .clk(clk), .rst(rst), .mem_read(mem_read4), .mem_write(mem_write4), .mem_addr(mem_addr4),
    .mem_wdata(mem_wdata4), .mem_rdata(mem_rdata4), .mem_ready(mem_ready4), .busy(busy4),
    .grant_ch(grant_ch4), .proto_err(proto_err4)
  );

  typedef struct {
    int           ch;
    bit           rd;
    logic [127:0] data;
  } exp_t;

  exp_t q[$];
  exp_t q4[$];
  exp_t e, e4;
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void expect0(input int ch, input bit rd, input logic [127:0] d);
    q.push_back('{ch: ch, rd: rd, data: d});
  endfunction

  // Monitors: outputs are stable through the cycle, so sample on the falling edge.
  always @(negedge clk) begin
    for (int c = 0; c < NCH; c++) begin
      if (mem_ready[c]) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready: channel %0d pulsed with nothing expected", c);
        end else begin
          e = q.pop_front();
          check("ready_channel", c, e.ch);
          if (e.rd) check("read_data", mem_rdata[c*LW +: LW], e.data);
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (mem_ready4[c]) begin
        if (q4.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ready4: channel %0d pulsed with nothing expected", c);
        end else begin
          e4 = q4.pop_front();
          check("ready_channel4", c, e4.ch);
          if (e4.rd) check("read_data4", {112'b0, mem_rdata4[c*16 +: 16]}, e4.data);
        end
      end
    end
  end

  // One transaction on the main DUT from an idle state; checks latency and busy span,
  // then leaves one idle cycle so the next call also starts from IDLE.
  task automatic txn(input int ch, input bit wr, input bit rd, input logic [AW-1:0] addr,
                     input logic [LW-1:0] wd);
    int lat = 0;
    int bcnt = 0;
    mem_addr[ch*AW +: AW]  = addr;
    mem_wdata[ch*LW +: LW] = wd;
    mem_read[ch]  = rd;
    mem_write[ch] = wr;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk); #1;
      if (busy) bcnt++;
      if (mem_ready[ch]) begin
        lat = n;
        break;
      end
    end
    mem_read[ch]  = 1'b0;
    mem_write[ch] = 1'b0;
    check("latency", lat, LAT);
    check("busy_cycles", bcnt, LAT);
    @(posedge clk); #1;
  endtask

  task automatic txn4(input int ch, input logic [7:0] addr, input logic [15:0] wd);
    int lat = 0;
    mem_addr4[ch*8 +: 8]   = addr;
    mem_wdata4[ch*16 +: 16] = wd;
    mem_write4[ch] = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk); #1;
      if (mem_ready4[ch]) begin
        lat = n;
        break;
      end
    end
    mem_write4[ch] = 1'b0;
    check("latency4", lat, 1);
    @(posedge clk); #1;
  endtask

  initial begin
    int cnt;
    int last;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_ready", mem_ready, 0);
    check("reset_grant_ch", grant_ch, 0);
    check("reset_proto_err", proto_err, 0);
    check("reset_rdata0", mem_rdata[0 +: LW], 0);
    check("reset_rdata1", mem_rdata[LW +: LW], 0);
    check("reset_busy4", busy4, 0);
    rst = 1'b0;

    // Preload through the write path.
    expect0(0, 0, 0); txn(0, 1'b1, 1'b0, 28'd5, PAA);
    expect0(1, 0, 0); txn(1, 1'b1, 1'b0, 28'd9, P99);
    check("rdata_after_writes", mem_rdata[0 +: LW], 0);

    // Basic read.
    expect0(0, 1, PAA); txn(0, 1'b0, 1'b1, 28'd5, '0);
    check("rdata0_held", mem_rdata[0 +: LW], PAA);
    check("grant_ch_read", grant_ch, 0);

    // Write on ch1 then read it back on ch0.
    expect0(1, 0, 0); txn(1, 1'b1, 1'b0, 28'd7, 128'h1234);
    check("grant_ch_write", grant_ch, 1);
    expect0(0, 1, 128'h1234); txn(0, 1'b0, 1'b1, 28'd7, '0);

    // Address wrap: 0x405 indexes line 5.
    expect0(1, 1, PAA); txn(1, 1'b0, 1'b1, 28'h0000405, '0);
    check("rdata0_kept", mem_rdata[0 +: LW], 128'h1234);
    check("proto_err_clear", proto_err, 0);

    // Read+write together: served as a write, proto_err sticks.
    expect0(1, 0, 0); txn(1, 1'b1, 1'b1, 28'd11, 128'h55);
    check("proto_err_set", proto_err, 1);
    expect0(0, 1, 128'h55); txn(0, 1'b0, 1'b1, 28'd11, '0);
    check("proto_err_sticky", proto_err, 1);
    check("rdata1_after_write", mem_rdata[LW +: LW], PAA);

    // Reset during BUSY of a ch1 write to line 9.
    mem_addr[LW'(0) + AW +: AW] = 28'd9;
    mem_wdata[LW +: LW] = 128'hDEAD;
    mem_write[1] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("busy_before_abort", busy, 1);
    rst = 1'b1;
    mem_write[1] = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", busy, 0);
    check("abort_ready", mem_ready, 0);
    check("abort_grant_ch", grant_ch, 0);
    check("abort_proto_err", proto_err, 0);
    check("abort_rdata0", mem_rdata[0 +: LW], 0);
    check("abort_rdata1", mem_rdata[LW +: LW], 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Contention at reset exit: ch0 first, then alternation; line 9 kept its old value.
    mem_addr[0 +: AW]  = 28'd5;
    mem_addr[AW +: AW] = 28'd9;
    expect0(0, 1, PAA); expect0(1, 1, P99); expect0(0, 1, PAA); expect0(1, 1, P99);
    mem_read = 2'b11;
    cnt = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (|mem_ready) cnt++;
      if (cnt == 4) break;
    end
    mem_read = 2'b00;
    check("alternation_count", cnt, 4);
    @(posedge clk); #1;

    // Four channels, LATENCY 1: preload, then all read together.
    for (int c = 0; c < 4; c++) begin
      q4.push_back('{ch: c, rd: 1'b0, data: 128'b0});
      txn4(c, 8'(c), 16'hC000 + 16'(c));
    end
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 4; c++)
        q4.push_back('{ch: c, rd: 1'b1, data: 128'hC000 + 128'(c)});
    for (int c = 0; c < 4; c++) mem_addr4[c*8 +: 8] = 8'(c);
    mem_read4 = 4'hF;
    cnt  = 0;
    last = 0;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      if (|mem_ready4) begin
        if (cnt > 0) check("rotation_gap", n - last, 2);
        last = n;
        cnt++;
        if (cnt == 8) break;
      end
    end
    mem_read4 = 4'h0;
    check("rotation_count", cnt, 8);

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    check("queue4_drained", q4.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multi_ch_slow_memory.md
# multi_ch_slow_memory

Parametrised, multi-channel successor to the single-port slow memory model. One line-organised backing store is shared by NUM_CH cache-side channels, for example I-cache and D-cache sharing a unified L2-side memory. A round-robin arbiter serves the channels one at a time, and each served request gets a fixed, configurable latency. The block sits on the testbench side of CHIP and replaces separate I/D slow memories when the unified-memory configuration is built.

## Interface
Parameters:
- NUM_CH, 2: number of requesting channels (1..8).
- ADDR_W, 28: line-address width per channel (byte address bits [31:4]).
- LINE_W, 128: line width in bits.
- DEPTH_LOG2, 10: log2 of the number of lines; the array holds 2^DEPTH_LOG2 lines.
- LATENCY, 4: cycles from grant to ready (>= 1).

Ports:
- clk, in, 1: single clock; all logic is rising-edge.
- rst, in, 1: synchronous, active-high reset.
- mem_read, in, NUM_CH: per-channel read request; level, held until ready.
- mem_write, in, NUM_CH: per-channel write request; level, held until ready.
- mem_addr, in, NUM_CH*ADDR_W: channel c occupies slice [c*ADDR_W +: ADDR_W].
- mem_wdata, in, NUM_CH*LINE_W: per-channel write line.
- mem_rdata, out, NUM_CH*LINE_W: per-channel read line.
- mem_ready, out, NUM_CH: one-cycle completion pulse per channel.
- busy, out, 1: a transaction is in flight.
- grant_ch, out, $clog2(NUM_CH) (min 1): channel currently being served.
- proto_err, out, 1: sticky; set when read and write are asserted together on one channel.

## Operation
- The backing array is named mem, with 2^DEPTH_LOG2 entries of LINE_W bits. It is not cleared by rst, so the testbench can preload it with $readmemb/$readmemh.
- Only the low DEPTH_LOG2 bits of the address index the array; upper bits are ignored, so addresses wrap.
- FSM states:
  - IDLE: if any channel has read|write asserted, grant one channel → BUSY (LATENCY>1) or RESP (LATENCY==1).
  - BUSY: counter counts down; when it reaches 1 → RESP.
  - RESP: the granted channel's ready is high for exactly this cycle → IDLE.
- At grant, the following are captured: channel index, operation, index bits, and wdata.
  - Read: the array line is captured at grant and presented on that channel's mem_rdata from RESP onward.
  - Write: the array is updated at the clock edge ending RESP.
- Read and write asserted together on one channel: served as a write, and proto_err sets.
- Round-robin arbitration: the search starts at last_grant+1 modulo NUM_CH; last_grant updates at each grant.
- Requests arriving while BUSY/RESP wait; they are never lost while held.
- A request deasserted mid-transaction does not cancel it: the write still commits and ready still pulses.
- A channel's mem_rdata holds its value until that channel's next read response; write responses leave rdata unchanged.

## Timing
- Grant is sampled at edge t in IDLE; mem_ready[c] is high in the cycle following edge t+LATENCY-1.
- Total cost per transaction is LATENCY+1 cycles, because there is one IDLE cycle between transactions. Requesters therefore see deasserted inputs before the next arbitration.
- Read-after-write from any channel, granted after the write's RESP, returns the new data.
- Reset values:
  - state IDLE
  - mem_ready 0
  - mem_rdata all 0
  - busy 0
  - grant_ch 0
  - proto_err 0
  - last_grant NUM_CH-1, so channel 0 wins the first contention.
  - counter 0
- Reset during BUSY/RESP aborts the transaction: a pending write is not committed, and no ready is issued.
- busy is high in BUSY and RESP.

## Structure
- Package mem_model_pkg holds the state enum (IDLE, BUSY, RESP) and a clog2-with-minimum-1 width helper.
- Sub-module rr_arbiter (NUM_CH request vector, last_grant → one-hot and index grant) is combinational. Its pointer register lives in the parent.
- The counter width is $clog2(LATENCY+1).

## Test plan
- Preload mem[5]=0xAA..AA. Channel 0 reads addr 5 with LATENCY=4 → mem_ready[0] pulses exactly 4 cycles after grant, rdata slice 0 = 0xAA..AA, busy high for 4 cycles.
- Channel 1 writes 0x1234 to addr 7, then channel 0 reads addr 7 → channel 0 receives 0x1234.
- Both channels request at reset exit → channel 0 is served first, then channel 1. Continuous requests from both alternate 0,1,0,1.
- Address 0x0000405 with DEPTH_LOG2=10 → accesses mem[5]. Read and write asserted together on channel 1 → treated as write, proto_err=1 and it stays 1.
- rst asserted during BUSY of a write to addr 9 → mem[9] unchanged, no ready pulse, all outputs at reset values next cycle.
- LATENCY=1, NUM_CH=4, all channels reading → ready pulses rotate 0,1,2,3 on alternating cycles.
